// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared types and constants for the RTC bus-cycle sequencer
package rtc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        A_SU,
        A_STB,
        A_HD,
        GAP,
        D_STB,
        D_HD
    } rtc_state_e;

    localparam int unsigned DEF_T_SU  = 2;
    localparam int unsigned DEF_T_PW  = 10;
    localparam int unsigned DEF_T_HD  = 2;
    localparam int unsigned DEF_T_GAP = 4;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic ad;
        logic cs;
        logic rd;
        logic wr;
        logic frw;
    } rtc_pins_t;

    localparam rtc_pins_t PINS_IDLE = '{ad: 1'b1, cs: 1'b1, rd: 1'b1, wr: 1'b1, frw: 1'b0};

endpackage

// File: rtl/rtc_if.sv
// rtl/rtc_if.sv - request and RTC pin bundle between controller, sequencer and pads
interface rtc_if;
    logic access;
    logic read;
    logic ad;
    logic cs;
    logic rd;
    logic wr;
    logic frw;

    modport master (
        output access,
        output read,
        input  ad,
        input  cs,
        input  rd,
        input  wr,
        input  frw
    );

    modport slave (
        input  access,
        input  read,
        output ad,
        output cs,
        output rd,
        output wr,
        output frw
    );
endinterface

// File: rtl/rtc_phase_timer.sv
// rtl/rtc_phase_timer.sv - loadable down-counter that flags when a phase has run out
module rtc_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rtc_transfer.sv
// rtl/rtc_transfer.sv - one address+data bus transaction to a multiplexed-bus RTC per access edge
module rtc_transfer
    import rtc_pkg::*;
#(
    parameter int unsigned T_SU  = DEF_T_SU,
    parameter int unsigned T_PW  = DEF_T_PW,
    parameter int unsigned T_HD  = DEF_T_HD,
    parameter int unsigned T_GAP = DEF_T_GAP
) (
    input  logic clk,
    input  logic reset,
    rtc_if.slave bus
);

    localparam logic [CNT_W-1:0] SU_LD  = CNT_W'(T_SU - 1);
    localparam logic [CNT_W-1:0] PW_LD  = CNT_W'(T_PW - 1);
    localparam logic [CNT_W-1:0] HD_LD  = CNT_W'(T_HD - 1);
    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(T_GAP - 1);

    rtc_state_e       state, state_d;
    logic             access_q;
    logic             rd_q;
    logic             start;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             zero;
    rtc_pins_t        out_d, out_q;

    assign start = bus.access & ~access_q & (state == IDLE);

    rtc_phase_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .zero     (zero)
    );

    // Reset copies the live access level so a level held high through reset is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            access_q <= bus.access;
            rd_q     <= 1'b0;
            out_q    <= PINS_IDLE;
        end else begin
            state    <= state_d;
            access_q <= bus.access;
            if (start) begin
                rd_q <= bus.read;
            end
            out_q    <= out_d;
        end
    end

    always_comb begin
        state_d  = state;
        load     = 1'b0;
        load_val = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d  = A_SU;
                    load     = 1'b1;
                    load_val = SU_LD;
                end
            end
            A_SU: begin
                if (zero) begin
                    state_d  = A_STB;
                    load     = 1'b1;
                    load_val = PW_LD;
                end
            end
            A_STB: begin
                if (zero) begin
                    state_d  = A_HD;
                    load     = 1'b1;
                    load_val = HD_LD;
                end
            end
            A_HD: begin
                if (zero) begin
                    state_d  = GAP;
                    load     = 1'b1;
                    load_val = GAP_LD;
                end
            end
            GAP: begin
                if (zero) begin
                    state_d  = D_STB;
                    load     = 1'b1;
                    load_val = PW_LD;
                end
            end
            D_STB: begin
                if (zero) begin
                    state_d  = D_HD;
                    load     = 1'b1;
                    load_val = HD_LD;
                end
            end
            D_HD: begin
                if (zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FRW follows the data direction from GAP on so the buffer turns around before the read strobe.
    always_comb begin
        out_d = PINS_IDLE;
        case (state)
            A_SU: begin
                out_d.ad  = 1'b0;
                out_d.frw = 1'b1;
            end
            A_STB: begin
                out_d.ad  = 1'b0;
                out_d.cs  = 1'b0;
                out_d.wr  = 1'b0;
                out_d.frw = 1'b1;
            end
            A_HD: begin
                out_d.ad  = 1'b0;
                out_d.frw = 1'b1;
            end
            GAP: begin
                out_d.frw = ~rd_q;
            end
            D_STB: begin
                out_d.cs = 1'b0;
                if (rd_q) begin
                    out_d.rd  = 1'b0;
                    out_d.frw = 1'b0;
                end else begin
                    out_d.wr  = 1'b0;
                    out_d.frw = 1'b1;
                end
            end
            D_HD: begin
                out_d.frw = ~rd_q;
            end
            default: out_d = PINS_IDLE;
        endcase
    end

    assign bus.ad  = out_q.ad;
    assign bus.cs  = out_q.cs;
    assign bus.rd  = out_q.rd;
    assign bus.wr  = out_q.wr;
    assign bus.frw = out_q.frw;

endmodule

// File: tb/tb_rtc_transfer.sv
// tb/tb_rtc_transfer.sv - self-checking bench for rtc_transfer
module tb_rtc_transfer;

    localparam int TSU  = 2;
    localparam int TPW  = 10;
    localparam int THD  = 2;
    localparam int TGAP = 4;
    localparam int B1 = TSU;
    localparam int B2 = B1 + TPW;
    localparam int B3 = B2 + THD;
    localparam int B4 = B3 + TGAP;
    localparam int B5 = B4 + TPW;
    localparam int B6 = B5 + THD;
    localparam logic [4:0] IDLE_P = 5'b11110;

    typedef struct {
        bit         rdv;
        int         k;
        logic [4:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rtc_if bus();

    rtc_transfer #(
        .T_SU  (TSU),
        .T_PW  (TPW),
        .T_HD  (THD),
        .T_GAP (TGAP)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int m_pos  = 0;
    bit m_pend = 1'b0;
    bit m_prev = 1'b0;
    bit m_rd   = 1'b0;

    int ad_falls = 0;
    int ad_low   = 0;
    bit last_ad  = 1'b1;

    // Pins {ad,cs,rd,wr,frw} at output cycle pos (1..B6) of a transaction; 0 means idle.
    function automatic logic [4:0] exp_pins(int pos, bit rdx);
        logic ad, cs, rd, wr, frw;
        bit astb, dstb;
        if (pos == 0) return IDLE_P;
        astb = (pos > B1) && (pos <= B2);
        dstb = (pos > B4) && (pos <= B5);
        ad   = (pos <= B3) ? 1'b0 : 1'b1;
        cs   = (astb || dstb) ? 1'b0 : 1'b1;
        rd   = (dstb && rdx) ? 1'b0 : 1'b1;
        wr   = (astb || (dstb && !rdx)) ? 1'b0 : 1'b1;
        frw  = (pos <= B3) ? 1'b1 : (rdx ? 1'b0 : 1'b1);
        return {ad, cs, rd, wr, frw};
    endfunction

    function automatic logic [4:0] pins();
        return {bus.ad, bus.cs, bus.rd, bus.wr, bus.frw};
    endfunction

    task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit a, input bit rdv);
        bit idle_now, st;
        int np;
        if (r) begin
            m_pos  = 0;
            m_pend = 1'b0;
        end else begin
            idle_now = !m_pend && (m_pos == 0 || m_pos == B6);
            st = a && !m_prev && idle_now;
            np = m_pend ? 1 : ((m_pos > 0 && m_pos < B6) ? m_pos + 1 : 0);
            m_pend = st;
            if (st) m_rd = rdv;
            m_pos = np;
        end
        m_prev = a;
    endtask

    task automatic step(input bit r, input bit a, input bit rdv);
        bit viol;
        rst        = r;
        bus.access = a;
        bus.read   = rdv;
        @(posedge clk);
        model_edge(r, a, rdv);
        #1;
        chk("model", pins(), exp_pins(m_pos, m_rd));
        viol = (!bus.rd && !bus.wr) || (!bus.cs && bus.rd && bus.wr);
        chk_int("exclusive", int'(viol), 0);
        if (last_ad && !bus.ad) ad_falls++;
        if (!bus.ad) ad_low++;
        last_ad = bus.ad;
    endtask

    vec_t vecs[$];

    initial begin
        bit acc;
        bus.access = 1'b0;
        bus.read   = 1'b0;

        vecs = '{
            '{1'b1,  1, 5'b01111}, '{1'b1,  2, 5'b01111}, '{1'b1,  3, 5'b00101},
            '{1'b1, 12, 5'b00101}, '{1'b1, 13, 5'b01111}, '{1'b1, 14, 5'b01111},
            '{1'b1, 15, 5'b11110}, '{1'b1, 18, 5'b11110}, '{1'b1, 19, 5'b10010},
            '{1'b1, 28, 5'b10010}, '{1'b1, 29, 5'b11110}, '{1'b1, 30, 5'b11110},
            '{1'b1, 31, 5'b11110}, '{1'b0,  3, 5'b00101}, '{1'b0, 15, 5'b11111},
            '{1'b0, 19, 5'b10101}, '{1'b0, 28, 5'b10101}, '{1'b0, 29, 5'b11111},
            '{1'b0, 30, 5'b11111}, '{1'b0, 31, 5'b11110}
        };

        // reset with access held high, then released with access still high
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("reset_idle", pins(), IDLE_P);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("post_reset_level", pins(), IDLE_P);
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        foreach (vecs[v]) begin
            step(1'b0, 1'b1, vecs[v].rdv);
            for (int j = 1; j <= vecs[v].k; j++) step(1'b0, 1'b0, vecs[v].rdv);
            chk($sformatf("vec%0d_rd%0d_k%0d", v, vecs[v].rdv, vecs[v].k), pins(), vecs[v].exp);
            for (int j = vecs[v].k; j < 34; j++) step(1'b0, 1'b0, vecs[v].rdv);
        end

        // access held high far past the end of the transaction
        ad_falls = 0;
        for (int i = 0; i < 70; i++) step(1'b0, 1'b1, 1'b1);
        chk_int("held_once", ad_falls, 1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // access dropped and re-raised mid-transaction
        ad_falls = 0;
        step(1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 70; i++) step(1'b0, (i != 9) && (i <= 15), 1'b0);
        chk_int("retrigger_once", ad_falls, 1);

        // reset during the read data strobe, then a fresh write
        step(1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 20; i++) step(1'b0, 1'b1, 1'b1);
        chk("mid_dstb", pins(), 5'b10010);
        step(1'b1, 1'b1, 1'b1);
        chk("reset_mid", pins(), IDLE_P);
        step(1'b0, 1'b0, 1'b0);
        ad_low   = 0;
        ad_falls = 0;
        step(1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 31; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (i == 1)  chk("fresh_k1", pins(), 5'b01111);
            if (i == 30) chk("fresh_k30", pins(), 5'b11111);
            if (i == 31) chk("fresh_k31", pins(), IDLE_P);
        end
        chk_int("fresh_ad_low", ad_low, 14);
        chk_int("fresh_ad_falls", ad_falls, 1);

        // random traffic against the model
        acc = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) acc = ~acc;
            step(($urandom_range(0, 249) == 0), acc, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
